// File: rtl/ibex_ex_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ibex_ex_issue_ctrl_if
// Purpose  : ID <-> EX multicycle issue/retire handshake bundle
// Revision : 1.0
// ============================================================================
interface ibex_ex_issue_ctrl_if #(
    parameter int unsigned CntW = 6
);
    logic                  instr_valid_i;
    logic                  mult_sel_i;
    logic                  div_sel_i;
    logic                  instr_kill_i;
    logic                  wb_ready_i;
    logic                  ex_valid_i;
    logic [1:0]            imd_val_we_i;
    logic [1:0][33:0]      imd_val_d_i;
    logic [1:0][33:0]      imd_val_q_o;
    logic                  mult_en_o;
    logic                  div_en_o;
    logic                  alu_instr_first_cycle_o;
    logic                  multdiv_ready_id_o;
    logic                  instr_done_o;
    logic                  stall_o;
    logic [CntW-1:0]       ex_cycles_o;
    logic                  err_timeout_o;

    // The controller side
    modport slave (
        input  instr_valid_i, mult_sel_i, div_sel_i, instr_kill_i, wb_ready_i,
               ex_valid_i, imd_val_we_i, imd_val_d_i,
        output imd_val_q_o, mult_en_o, div_en_o, alu_instr_first_cycle_o,
               multdiv_ready_id_o, instr_done_o, stall_o, ex_cycles_o, err_timeout_o
    );

    // The ID/EX environment side
    modport master (
        output instr_valid_i, mult_sel_i, div_sel_i, instr_kill_i, wb_ready_i,
               ex_valid_i, imd_val_we_i, imd_val_d_i,
        input  imd_val_q_o, mult_en_o, div_en_o, alu_instr_first_cycle_o,
               multdiv_ready_id_o, instr_done_o, stall_o, ex_cycles_o, err_timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/ibex_ex_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ibex_ex_issue_ctrl
// Purpose  : ID-side issue/retire FSM for EX multicycle ops, imd regs, timeout
// Revision : 1.0
// ============================================================================
module ibex_ex_issue_ctrl #(
    parameter int unsigned MaxCycles = 40,
    parameter int unsigned CntW      = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    ibex_ex_issue_ctrl_if.slave    bus
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;

    localparam int unsigned           c_busy_w   = (MaxCycles < 2) ? 1 : $clog2(MaxCycles + 1);
    localparam logic [c_busy_w-1:0]   c_busy_max = c_busy_w'(MaxCycles);
    localparam logic [CntW-1:0]       c_cnt_max  = {CntW{1'b1}};

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                w_live;
    logic                w_issue;
    logic                w_done;
    logic [CntW-1:0]     r_ex_cycles;
    logic [c_busy_w-1:0] r_busy_cnt;
    logic                r_err_timeout;
    logic [1:0][33:0]    r_imd_q;

    assign w_live  = bus.instr_valid_i & ~bus.instr_kill_i;
    assign w_issue = (r_state == c_st_idle) & w_live;

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        if (!w_live) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.ex_valid_i) begin
                        if (bus.wb_ready_i) w_done      = 1'b1;
                        else                w_state_nxt = c_st_hold;
                    end else begin
                        w_state_nxt = c_st_busy;
                    end
                end
                c_st_busy: begin
                    if (bus.ex_valid_i) begin
                        if (bus.wb_ready_i) begin
                            w_done      = 1'b1;
                            w_state_nxt = c_st_idle;
                        end else begin
                            w_state_nxt = c_st_hold;
                        end
                    end
                end
                c_st_hold: begin
                    if (bus.wb_ready_i) begin
                        w_done      = 1'b1;
                        w_state_nxt = c_st_idle;
                    end
                end
                default: w_state_nxt = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= c_st_idle;
        else         r_state <= w_state_nxt;
    end

    // Cycle counter keeps its value after retire so the last latency stays visible
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ex_cycles <= '0;
        end else if (bus.instr_kill_i || w_issue) begin
            r_ex_cycles <= '0;
        end else if ((r_state != c_st_idle) && (r_ex_cycles != c_cnt_max)) begin
            r_ex_cycles <= r_ex_cycles + 1'b1;
        end
    end

    // Only cycles spent waiting on EX count towards the timeout, not writeback stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy_cnt    <= '0;
            r_err_timeout <= 1'b0;
        end else if (w_issue) begin
            r_busy_cnt    <= '0;
            r_err_timeout <= 1'b0;
        end else if ((r_state == c_st_busy) && !bus.instr_kill_i) begin
            if (r_busy_cnt != c_busy_max) r_busy_cnt <= r_busy_cnt + 1'b1;
            if ((MaxCycles != 0) && (32'(r_busy_cnt) == MaxCycles - 1)) r_err_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_imd_q <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (bus.imd_val_we_i[k] && w_live) r_imd_q[k] <= bus.imd_val_d_i[k];
            end
        end
    end

    assign bus.imd_val_q_o             = r_imd_q;
    assign bus.mult_en_o               = w_live & bus.mult_sel_i;
    assign bus.div_en_o                = w_live & bus.div_sel_i;
    assign bus.alu_instr_first_cycle_o = w_issue;
    assign bus.multdiv_ready_id_o      = w_live & bus.wb_ready_i;
    assign bus.instr_done_o            = w_done;
    assign bus.stall_o                 = bus.instr_valid_i & ~w_done;
    assign bus.ex_cycles_o             = r_ex_cycles;
    assign bus.err_timeout_o           = r_err_timeout;

`ifndef SYNTHESIS
    // ID must hold an instruction until it retires or is flushed
    a_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.instr_valid_i && !bus.instr_done_o && !bus.instr_kill_i) |=> bus.instr_valid_i);
    a_sel_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.instr_valid_i |-> !(bus.mult_sel_i && bus.div_sel_i));
`endif

endmodule
`default_nettype wire

// File: tb/tb_ibex_ex_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ibex_ex_issue_ctrl
// Purpose  : directed + random bench for ibex_ex_issue_ctrl with a reference model
// Revision : 1.0
// ============================================================================
module tb_ibex_ex_issue_ctrl;

    localparam int unsigned MAXC = 4;
    localparam int unsigned CNTW = 3;
    localparam int unsigned SATV = (1 << CNTW) - 1;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    // Reference model: tracks "an instruction is in flight" and "its result arrived"
    bit           m_active;
    bit           m_got;
    int           m_cycles;
    int           m_busy;
    bit           m_err;
    logic [33:0]  m_imd [2];
    bit           m_done_last;

    ibex_ex_issue_ctrl_if #(.CntW(CNTW)) bus ();

    ibex_ex_issue_ctrl #(.MaxCycles(MAXC), .CntW(CNTW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input bit mul, input bit div, input bit kill,
                        input bit wb, input bit exv, input logic [1:0] we,
                        input logic [33:0] d0, input logic [33:0] d1);
        bit live;
        bit e_done;
        @(negedge clk);
        bus.instr_valid_i  = v;
        bus.mult_sel_i     = mul;
        bus.div_sel_i      = div;
        bus.instr_kill_i   = kill;
        bus.wb_ready_i     = wb;
        bus.ex_valid_i     = exv;
        bus.imd_val_we_i   = we;
        bus.imd_val_d_i[0] = d0;
        bus.imd_val_d_i[1] = d1;
        #2;
        live   = v && !kill;
        e_done = live && wb && (exv || m_got);
        chk("mult_en",     34'(bus.mult_en_o),               34'(live && mul));
        chk("div_en",      34'(bus.div_en_o),                34'(live && div));
        chk("first_cycle", 34'(bus.alu_instr_first_cycle_o), 34'(live && !m_active));
        chk("ready",       34'(bus.multdiv_ready_id_o),      34'(live && wb));
        chk("done",        34'(bus.instr_done_o),            34'(e_done));
        chk("stall",       34'(bus.stall_o),                 34'(v && !e_done));
        chk("ex_cycles",   34'(bus.ex_cycles_o),             34'(m_cycles));
        chk("err_timeout", 34'(bus.err_timeout_o),           34'(m_err));
        chk("imd_q0",      bus.imd_val_q_o[0],               m_imd[0]);
        chk("imd_q1",      bus.imd_val_q_o[1],               m_imd[1]);

        if (live && we[0]) m_imd[0] = d0;
        if (live && we[1]) m_imd[1] = d1;
        if (kill) begin
            m_active = 0;
            m_got    = 0;
            m_cycles = 0;
        end else begin
            if (v && !m_active) begin
                m_err    = 0;
                m_cycles = 0;
                m_busy   = 0;
            end else if (m_active) begin
                if (m_cycles < SATV) m_cycles++;
                if (!m_got) begin
                    m_busy++;
                    if (MAXC != 0 && m_busy == MAXC) m_err = 1;
                end
            end
            if (e_done) begin
                m_active = 0;
                m_got    = 0;
            end else if (v) begin
                m_active = 1;
                m_got    = m_got || exv;
            end
        end
        m_done_last = e_done;
    endtask

    initial begin
        bit          have;
        bit          cv, cm, cd, ck, cw, cx;
        logic [1:0]  cwe;
        logic [33:0] r0, r1;
        int          kind;

        n_cmp = 0; n_err = 0;
        m_active = 0; m_got = 0; m_cycles = 0; m_busy = 0; m_err = 0;
        m_imd[0] = '0; m_imd[1] = '0; m_done_last = 0;
        bus.instr_valid_i = 0; bus.mult_sel_i = 0; bus.div_sel_i = 0;
        bus.instr_kill_i = 0; bus.wb_ready_i = 0; bus.ex_valid_i = 0;
        bus.imd_val_we_i = '0; bus.imd_val_d_i = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state, nothing presented
        step(0, 0, 0, 0, 1, 0, 2'b00, '0, '0);

        // Single-cycle ALU op
        step(1, 0, 0, 0, 1, 1, 2'b00, '0, '0);
        step(0, 0, 0, 0, 1, 0, 2'b00, '0, '0);

        // MUL finishing in cycle 3
        step(1, 1, 0, 0, 1, 0, 2'b00, '0, '0);
        step(1, 1, 0, 0, 1, 0, 2'b00, '0, '0);
        step(1, 1, 0, 0, 1, 0, 2'b00, '0, '0);
        step(1, 1, 0, 0, 1, 1, 2'b00, '0, '0);
        step(0, 0, 0, 0, 1, 0, 2'b00, '0, '0);
        chk("mul_latency", 34'(bus.ex_cycles_o), 34'd3);

        // DIV result held while writeback is blocked
        step(1, 0, 1, 0, 0, 0, 2'b00, '0, '0);
        step(1, 0, 1, 0, 0, 1, 2'b00, '0, '0);
        step(1, 0, 1, 0, 0, 0, 2'b00, '0, '0);
        step(1, 0, 1, 0, 1, 0, 2'b00, '0, '0);
        step(0, 0, 0, 0, 1, 0, 2'b00, '0, '0);

        // Intermediate register write, then a killed write
        step(1, 0, 0, 0, 1, 1, 2'b01, 34'h2_DEAD_BEEF, 34'h1_2345_6789);
        step(0, 0, 0, 0, 1, 0, 2'b00, '0, '0);
        chk("imd_write", bus.imd_val_q_o[0], 34'h2_DEAD_BEEF);
        step(1, 0, 0, 1, 1, 1, 2'b11, 34'h0_1111_2222, 34'h3_3333_4444);
        step(0, 0, 0, 0, 1, 0, 2'b00, '0, '0);

        // Kill in BUSY
        step(1, 1, 0, 0, 1, 0, 2'b00, '0, '0);
        step(1, 1, 0, 0, 1, 0, 2'b00, '0, '0);
        step(1, 1, 0, 1, 1, 0, 2'b00, '0, '0);
        step(0, 0, 0, 0, 1, 0, 2'b00, '0, '0);

        // Timeout and counter saturation, then cleared by the next issue
        step(1, 0, 1, 0, 1, 0, 2'b00, '0, '0);
        for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 1, 0, 2'b00, '0, '0);
        step(1, 0, 1, 0, 1, 1, 2'b00, '0, '0);
        step(0, 0, 0, 0, 1, 0, 2'b00, '0, '0);
        chk("timeout_set", 34'(bus.err_timeout_o), 34'd1);
        step(1, 0, 0, 0, 1, 1, 2'b00, '0, '0);
        step(0, 0, 0, 0, 1, 0, 2'b00, '0, '0);

        // Randomized traffic obeying the ID protocol
        have = 0; cm = 0; cd = 0;
        for (int i = 0; i < 600; i++) begin
            if (!have) begin
                cv   = ($urandom_range(9) < 7);
                kind = $urandom_range(2);
                cm   = (kind == 1);
                cd   = (kind == 2);
            end else begin
                cv = 1;
            end
            ck  = ($urandom_range(15) == 0);
            cw  = ($urandom_range(2) != 0);
            cx  = ($urandom_range(3) == 0);
            cwe = 2'($urandom_range(3));
            r0[31:0]  = $urandom;
            r0[33:32] = 2'($urandom_range(3));
            r1[31:0]  = $urandom;
            r1[33:32] = 2'($urandom_range(3));
            step(cv, cm, cd, ck, cw, cx, cwe, r0, r1);
            have = cv && !ck && !m_done_last;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
